// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR handshake: captures one request in IDLE,
// performs it after WAIT_CYCLES busy cycles, pulses MFC, then waits for memEn to drop.
//
// state   | meaning
// IDLE    | waiting for memEn; captures addr/memOp/wdata on acceptance
// BUSY    | counting down the programmed wait; access performed on leaving
// ACK     | MFC high for this single cycle
// RELEASE | holds until memEn is low so a stuck strobe cannot retrigger
module memory_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memEn,
  input  logic              memOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              memBusy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_we;

  // Storage is intentionally left without reset; contents are undefined until written.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // mem_we decodes from state, so an async reset in BUSY cancels a pending write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memEn) begin
          addr_d  = addr;
          op_d    = memOp;
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ACK;
          if (op_q) begin
            rdata_d = mem[addr_q];
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!memEn) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata   = rdata_q;
  assign MFC     = (state_q == ACK);
  assign memBusy = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances (wait 2, 0, 5) sharing
// clock, reset and address/data inputs, each with its own memEn strobe.
module tb_memory_responder;

  logic       clk;
  logic       reset;
  logic       memOp;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       en   [3];
  logic       mfc  [3];
  logic       busy [3];
  logic [7:0] rd   [3];

  int checks = 0;
  int errors = 0;

  // Index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0, index 2: WAIT_CYCLES=5
  memory_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .memEn(en[0]), .memOp(memOp), .addr(addr),
    .wdata(wdata), .rdata(rd[0]), .MFC(mfc[0]), .memBusy(busy[0]));
  memory_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .memEn(en[1]), .memOp(memOp), .addr(addr),
    .wdata(wdata), .rdata(rd[1]), .MFC(mfc[1]), .memBusy(busy[1]));
  memory_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(5)) u_w5 (
    .clk(clk), .reset(reset), .memEn(en[2]), .memOp(memOp), .addr(addr),
    .wdata(wdata), .rdata(rd[2]), .MFC(mfc[2]), .memBusy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full handshake on instance sel; hold = extra RELEASE cycles with memEn high.
  task automatic req(input int sel, input logic op, input logic [5:0] a,
                     input logic [7:0] d, input int hold, input bit disturb,
                     input int exp_lat, input string tag, output logic [7:0] rd_out);
    int n;
    memOp   = op;
    addr    = a;
    wdata   = d;
    en[sel] = 1'b1;
    tick();
    chk({tag, "_busy_rise"}, 32'(busy[sel]), 32'd1);
    if (disturb) begin
      addr  = 6'd7;
      wdata = 8'h3C;
      memOp = ~op;
    end
    n = 0;
    while (mfc[sel] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_mfc_latency"}, 32'(n), 32'(exp_lat));
    rd_out = rd[sel];
    for (int i = 0; i <= hold; i++) begin
      tick();
      chk({tag, "_mfc_low"}, 32'(mfc[sel]), 32'd0);
      chk({tag, "_release_busy"}, 32'(busy[sel]), 32'd1);
    end
    en[sel] = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    reset = 1'b1;
    memOp = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    tick();
    tick();
    chk("rst_mfc", 32'(mfc[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_rdata", 32'(rd[0]), 32'd0);
    reset = 1'b0;
    tick();

    // 1: reset asserted mid-cycle while a request is in flight
    en[0] = 1'b1;
    addr  = 6'd5;
    wdata = 8'h44;
    tick();
    chk("t1_busy_before_rst", 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_mfc", 32'(mfc[0]), 32'd0);
    chk("t1_rst_busy", 32'(busy[0]), 32'd0);
    chk("t1_rst_rdata", 32'(rd[0]), 32'd0);
    en[0] = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_stay_idle", 32'(busy[0]), 32'd0);
      chk("t1_no_mfc", 32'(mfc[0]), 32'd0);
    end

    // 2: write then read, wait 2
    req(0, 1'b0, 6'd3, 8'hA5, 0, 1'b0, 3, "t2_wr", r);
    chk("t2_wr_rdata_unchanged", 32'(r), 32'h00);
    req(0, 1'b1, 6'd3, 8'h00, 0, 1'b0, 3, "t2_rd", r);
    chk("t2_rd_data", 32'(r), 32'hA5);
    tick();
    chk("t2_rdata_hold", 32'(rd[0]), 32'hA5);

    // 3: latency sweep with wait 0 and wait 5
    req(1, 1'b0, 6'd2, 8'h5A, 0, 1'b0, 1, "t3_w0_wr", r);
    req(1, 1'b1, 6'd2, 8'h00, 0, 1'b0, 1, "t3_w0_rd", r);
    chk("t3_w0_data", 32'(r), 32'h5A);
    req(2, 1'b0, 6'd10, 8'hC3, 0, 1'b0, 6, "t3_w5_wr", r);
    req(2, 1'b1, 6'd10, 8'h00, 0, 1'b0, 6, "t3_w5_rd", r);
    chk("t3_w5_data", 32'(r), 32'hC3);

    // 4: memEn stuck high for 10 cycles after MFC
    req(0, 1'b0, 6'd4, 8'h77, 10, 1'b0, 3, "t4_stuck", r);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_retrigger_busy", 32'(busy[0]), 32'd0);
      chk("t4_no_retrigger_mfc", 32'(mfc[0]), 32'd0);
    end

    // 5: inputs disturbed during BUSY are ignored
    req(0, 1'b0, 6'd7, 8'h00, 0, 1'b0, 3, "t5_pre7", r);
    req(0, 1'b0, 6'd1, 8'h11, 0, 1'b1, 3, "t5_wr1", r);
    req(0, 1'b1, 6'd1, 8'h00, 0, 1'b0, 3, "t5_rd1", r);
    chk("t5_addr1", 32'(r), 32'h11);
    req(0, 1'b1, 6'd7, 8'h00, 0, 1'b0, 3, "t5_rd7", r);
    chk("t5_addr7", 32'(r), 32'h00);

    // 6: reset in BUSY cancels the overwrite of addr 9
    req(0, 1'b0, 6'd9, 8'h22, 0, 1'b0, 3, "t6_pre", r);
    memOp = 1'b0;
    addr  = 6'd9;
    wdata = 8'hFF;
    en[0] = 1'b1;
    tick();
    tick();
    chk("t6_busy", 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_rst_mfc", 32'(mfc[0]), 32'd0);
      chk("t6_rst_busy", 32'(busy[0]), 32'd0);
    end
    en[0] = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_post_mfc", 32'(mfc[0]), 32'd0);
    end
    req(0, 1'b1, 6'd9, 8'h00, 0, 1'b0, 3, "t6_rd9", r);
    chk("t6_addr9", 32'(r), 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side responder for the processor's MAR/MDR memory interface. It accepts one read or write request per handshake from a control FSM (store, load, fetch) and performs it on an internal word array. It then pulses MFC (memory function complete) after a programmable wait. It stands in for main memory in the datapath and closes the memEn/memOp/MFC handshake that the control FSMs initiate.

## Interface
- ADDR_W, default 6, address width; array depth is 2**ADDR_W words.
- DATA_W, default 8, word width.
- WAIT_CYCLES, default 2, extra busy cycles before MFC; legal range 0..15.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- memEn  input  1  request strobe from the initiator; held high until MFC is sampled.
- memOp  input  1  0 = write (store), 1 = read (load).
- addr  input  ADDR_W  word address, driven from MAR.
- wdata  input  DATA_W  write data, driven from MDR.
- rdata  output  DATA_W  read data, registered.
- MFC  output  1  one-cycle completion pulse.
- memBusy  output  1  high whenever state != IDLE.

## Operation
- States: IDLE, BUSY, ACK, RELEASE.
- IDLE:
  - If memEn=1 at a clock edge, capture addr, memOp and wdata into internal registers.
  - Load the wait counter with WAIT_CYCLES and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If the counter is nonzero, decrement it and stay in BUSY.
  - If the counter is 0, go to ACK and, on that same edge:
    - captured op = write: mem[captured addr] <= captured wdata.
    - captured op = read: rdata <= mem[captured addr].
- ACK:
  - MFC=1 for exactly this one cycle.
  - Always go to RELEASE.
- RELEASE:
  - Go to IDLE when memEn=0; otherwise stay, which blocks a stuck-high memEn from retriggering.
  - MFC=0 in this state.
- Only the values captured in IDLE are used. Changes on addr, wdata, memOp or memEn while in BUSY are ignored.
- A request abandoned mid-BUSY (memEn dropped) still completes, including the write and the MFC pulse. It then passes through RELEASE to IDLE.
- rdata holds its value until the next read completes; writes leave rdata unchanged.
- The array is not reset. Its contents are undefined until written.
- Reset values: state IDLE, MFC 0, memBusy 0, rdata 0, counter 0, capture registers 0.
- Reset mid-operation returns to IDLE immediately.
  - A write commits only if the BUSY->ACK edge occurred before reset.
  - No MFC is emitted for an interrupted request.

## Timing
- Let edge E0 be the edge where IDLE samples memEn=1.
- The write commit / rdata update occurs at edge E0+WAIT_CYCLES+1.
- MFC is high between edges E0+WAIT_CYCLES+1 and E0+WAIT_CYCLES+2.
- The initiator samples MFC=1 at edge E0+WAIT_CYCLES+2 and deasserts memEn in the following cycle.
- The earliest return to IDLE is edge E0+WAIT_CYCLES+3, if memEn is already low there.
- With WAIT_CYCLES=0, MFC rises one edge after acceptance.
- Minimum spacing between accepted requests is WAIT_CYCLES+4 edges.
- rdata is valid in the MFC cycle and stable afterwards.
- memBusy rises at E0 and falls on the edge entering IDLE.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Test plan
1. Reset behaviour: assert reset mid-cycle with memEn=1.
   - Required: MFC=0, memBusy=0 and rdata=0 immediately.
   - Required: after release with memEn=0, the block stays IDLE.
2. Write then read: write 8'hA5 to addr 6'd3 (memOp=0), drop memEn after MFC, then read addr 6'd3 (memOp=1).
   - Required: rdata=8'hA5 in the MFC cycle.
   - Required: MFC rises exactly 3 edges after acceptance with WAIT_CYCLES=2.
3. Latency sweep: run WAIT_CYCLES = 0 and 5.
   - Required: MFC rises 1 and 6 edges after acceptance respectively.
   - Required: MFC is exactly one cycle wide in both runs.
4. Stuck memEn: hold memEn=1 for 10 cycles after MFC.
   - Required: a single MFC pulse and memBusy=1 throughout (RELEASE).
   - Required: IDLE one edge after memEn falls, and no second access.
5. Input stability: change addr to 6'd7 and wdata to 8'h3C during BUSY of a write to addr 6'd1 with 8'h11.
   - Required: reading back gives addr 1 = 8'h11.
   - Required: addr 7 is unchanged from its prior written value 8'h00.
6. Reset during BUSY of a write of 8'hFF to addr 6'd9 that was preceded by writing 8'h22 there.
   - Required: MFC never pulses.
   - Required: a subsequent read of addr 9 returns 8'h22.
